// File: rtl/svc_rv_uart_pkg.sv
// Shared definitions for the MMIO UART transmitter.
// - Register indices, decoded from address bits [3:2].
// - STATUS bit positions.
// - Serializer state encoding. The PARITY state exists only when
//   SVC_RV_UART_TX_PARITY_EN is defined.
package svc_rv_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  localparam int unsigned STATUS_BUSY_BIT   = 0;
  localparam int unsigned STATUS_FULL_BIT   = 1;
  localparam int unsigned STATUS_EMPTY_BIT  = 2;
  localparam int unsigned STATUS_OVF_BIT    = 3;
  localparam int unsigned STATUS_PARITY_BIT = 4;
  localparam int unsigned STATUS_COUNT_LSB  = 8;

`ifdef SVC_RV_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/svc_rv_mmio_uart_tx_if.sv
// RV SoC MMIO bus as seen by an io device (SRAM-style timing).
// - io_raddr : read byte address
// - io_rdata : read data, valid one cycle after io_raddr
// - io_wen   : write enable
// - io_waddr : write byte address
// - io_wdata : write data
// - io_wstrb : write byte strobes
// master = SoC side, slave = device side.
interface svc_rv_mmio_uart_tx_if;

  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;

  modport master (
    output io_raddr,
    output io_wen,
    output io_waddr,
    output io_wdata,
    output io_wstrb,
    input  io_rdata
  );

  modport slave (
    input  io_raddr,
    input  io_wen,
    input  io_waddr,
    input  io_wdata,
    input  io_wstrb,
    output io_rdata
  );

endinterface

// File: rtl/svc_rv_uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read port.
// - clk, rst : clock, synchronous active-high reset (flushes contents)
// - push     : write wdata; accepted when not full, or when pop fires too
// - pop      : drop head entry; ignored when empty
// - wdata    : byte to push
// - rdata    : current head entry (valid while !empty)
// - full     : count == depth
// - empty    : count == 0
// - count    : occupancy, AW+1 bits, saturates at depth
module svc_rv_uart_tx_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam int unsigned Depth    = 1 << AW;
  localparam logic [AW:0] DepthCnt = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/svc_rv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the RV SoC MMIO bus.
// CPU stores bytes into TXDATA; a serializer drains the FIFO at a bit period
// of CLKDIV+1 clocks. Reads are registered (SRAM timing, 1-cycle latency).
// Ports:
// - clk  : system clock
// - rst  : synchronous active-high reset
// - bus  : MMIO slave port (io_raddr/io_rdata/io_wen/io_waddr/io_wdata/io_wstrb)
// - txd  : serial output, idle high
// - busy : FIFO non-empty or serializer active (registered)
// Build option: define SVC_RV_UART_TX_PARITY_EN to append an even-parity bit
// after the data bits; STATUS bit4 then reads 1.
module svc_rv_mmio_uart_tx
  import svc_rv_uart_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 3,
  parameter logic [15:0] CLKDIV_RST = 16'd867
) (
  input  logic                   clk,
  input  logic                   rst,
  svc_rv_mmio_uart_tx_if.slave   bus,
  output logic                   txd,
  output logic                   busy
);

  logic [1:0] wr_idx, rd_idx;
  logic       push, ovf_clr;

  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty, pop;
  logic [FIFO_AW:0] fifo_count;

  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;
  logic           ovf_q;
  logic [15:0]    clkdiv_q;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    status;

  logic unused_bits;
  assign unused_bits = ^{bus.io_waddr[31:4], bus.io_waddr[1:0], bus.io_raddr[31:4],
                         bus.io_raddr[1:0], bus.io_wdata[31:16], bus.io_wstrb[3:2]};

  // Register decode
  assign wr_idx  = bus.io_waddr[3:2];
  assign rd_idx  = bus.io_raddr[3:2];
  assign push    = bus.io_wen & (wr_idx == REG_TXDATA) & bus.io_wstrb[0];
  assign ovf_clr = bus.io_wen & (wr_idx == REG_STATUS) & bus.io_wstrb[0] & bus.io_wdata[3];

  svc_rv_uart_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.io_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                                     = '0;
    status[STATUS_BUSY_BIT]                    = busy_q;
    status[STATUS_FULL_BIT]                    = fifo_full;
    status[STATUS_EMPTY_BIT]                   = fifo_empty;
    status[STATUS_OVF_BIT]                     = ovf_q;
`ifdef SVC_RV_UART_TX_PARITY_EN
    status[STATUS_PARITY_BIT]                  = 1'b1;
`endif
    status[STATUS_COUNT_LSB +: FIFO_AW+1]      = fifo_count;
  end

  // Readback uses pre-write state; registered below.
  always_comb begin
    rdata_d = '0;
    case (rd_idx)
      REG_STATUS: rdata_d = status;
      REG_CLKDIV: rdata_d = {16'h0000, clkdiv_q};
      default:    rdata_d = '0;
    endcase
  end

  // Serializer next-state. Each bit lasts baud_q+1 cycles; the counter reloads
  // from clkdiv_q only at a bit start, so CLKDIV writes never cut a bit short.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rdata;
          parity_d = ^fifo_rdata;
          baud_d   = clkdiv_q;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_q == 16'd0) begin
          baud_d  = clkdiv_q;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      StData: begin
        if (baud_q == 16'd0) begin
          baud_d = clkdiv_q;
          if (bit_q == 3'd7) begin
`ifdef SVC_RV_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef SVC_RV_UART_TX_PARITY_EN
      StParity: begin
        if (baud_q == 16'd0) begin
          baud_d  = clkdiv_q;
          state_d = StStop;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      StStop: begin
        if (baud_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // txd is registered from the next state so it lines up with state_q.
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
`ifdef SVC_RV_UART_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase

    busy_d = (state_q != StIdle) | ~fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      clkdiv_q <= CLKDIV_RST;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      if (push && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (bus.io_wen && (wr_idx == REG_CLKDIV)) begin
        if (bus.io_wstrb[0]) clkdiv_q[7:0]  <= bus.io_wdata[7:0];
        if (bus.io_wstrb[1]) clkdiv_q[15:8] <= bus.io_wdata[15:8];
      end
    end
  end

  assign bus.io_rdata = rdata_q;
  assign txd          = txd_q;
  assign busy         = busy_q;

endmodule
